// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared opcodes, widths and entry types for the reservation station
package reservation_station_pkg;

  localparam int OP_LOG         = 5;
  localparam int ROB_LOG        = 4;
  localparam int RS_LOG_DEFAULT = 4;

  localparam logic [OP_LOG-1:0] OP_NOP   = 5'd0;
  localparam logic [OP_LOG-1:0] OP_ADD   = 5'd1;
  localparam logic [OP_LOG-1:0] OP_SUB   = 5'd2;
  localparam logic [OP_LOG-1:0] OP_ADDI  = 5'd3;
  localparam logic [OP_LOG-1:0] OP_AND   = 5'd4;
  localparam logic [OP_LOG-1:0] OP_OR    = 5'd5;
  localparam logic [OP_LOG-1:0] OP_XOR   = 5'd6;
  localparam logic [OP_LOG-1:0] OP_SLT   = 5'd7;
  localparam logic [OP_LOG-1:0] OP_SLL   = 5'd8;
  localparam logic [OP_LOG-1:0] OP_BEQ   = 5'd9;
  localparam logic [OP_LOG-1:0] OP_BNE   = 5'd10;
  localparam logic [OP_LOG-1:0] OP_BLT   = 5'd11;
  localparam logic [OP_LOG-1:0] OP_JAL   = 5'd12;
  localparam logic [OP_LOG-1:0] OP_JALR  = 5'd13;
  localparam logic [OP_LOG-1:0] OP_LUI   = 5'd14;
  localparam logic [OP_LOG-1:0] OP_AUIPC = 5'd15;

  // One source operand: either a value, or a pending ROB tag
  typedef struct packed {
    logic                busy;
    logic [ROB_LOG-1:0]  tag;
    logic [31:0]         value;
  } operand_t;

  typedef struct packed {
    logic                busy;
    logic [OP_LOG-1:0]   op;
    operand_t            j;
    operand_t            k;
    logic [31:0]         imm;
    logic [ROB_LOG-1:0]  dest_rob;
    logic [31:0]         cur_pc;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_LOG-1:0]   op;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic [31:0]         imm;
    logic [31:0]         cur_pc;
    logic [ROB_LOG-1:0]  dest_rob;
  } rs_out_t;

  // Capture a broadcast result into a pending operand; the ALU bus wins a tag tie
  function automatic operand_t snoop(
    input operand_t           opnd,
    input logic               alu_en,
    input logic [ROB_LOG-1:0] alu_tag,
    input logic [31:0]        alu_val,
    input logic               lsb_en,
    input logic [ROB_LOG-1:0] lsb_tag,
    input logic [31:0]        lsb_val
  );
    operand_t res;
    res = opnd;
    if (opnd.busy && alu_en && (opnd.tag == alu_tag)) begin
      res.busy  = 1'b0;
      res.value = alu_val;
    end else if (opnd.busy && lsb_en && (opnd.tag == lsb_tag)) begin
      res.busy  = 1'b0;
      res.value = lsb_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// rtl/reservation_station_select.sv - lowest-index priority encoder over a request vector
module rs_select #(
  parameter int LOG = 4
) (
  input  logic [(1<<LOG)-1:0] req,
  output logic [LOG-1:0]      idx,
  output logic                found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = (1 << LOG) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = LOG'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order issue buffer feeding the ALU-class functional unit
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_LOG = RS_LOG_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_flag,
  input  logic               issue_valid,
  input  logic [OP_LOG-1:0]  issue_op,
  input  logic [31:0]        issue_Vj,
  input  logic [31:0]        issue_Vk,
  input  logic               issue_Qj_busy,
  input  logic               issue_Qk_busy,
  input  logic [ROB_LOG-1:0] issue_Qj,
  input  logic [ROB_LOG-1:0] issue_Qk,
  input  logic [31:0]        issue_Imm,
  input  logic [31:0]        issue_CurPC,
  input  logic [ROB_LOG-1:0] issue_DestRob,
  output logic               full,
  input  logic               alu_enable,
  input  logic [ROB_LOG-1:0] alu_RobId,
  input  logic [31:0]        alu_value,
  input  logic               lsb_enable,
  input  logic [ROB_LOG-1:0] lsb_RobId,
  input  logic [31:0]        lsb_value,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  localparam int RS_N = 1 << RS_LOG;

  rs_entry_t         ent_q [RS_N];
  rs_entry_t         ent_d [RS_N];
  rs_out_t           out_q;
  rs_out_t           out_d;
  logic              rs_valid_q;
  logic              rs_valid_d;

  logic [RS_N-1:0]   busy_vec;
  logic [RS_N-1:0]   ready_vec;
  logic [RS_LOG-1:0] free_idx;
  logic [RS_LOG-1:0] ready_idx;
  logic              free_found;
  logic              ready_found;
  operand_t          new_j;
  operand_t          new_k;

  // Occupancy and readiness come from registered state only
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_N; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].j.busy && !ent_q[i].k.busy;
    end
  end

  assign full = &busy_vec;

  rs_select #(.LOG(RS_LOG)) u_free_sel (
    .req   (~busy_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_select #(.LOG(RS_LOG)) u_ready_sel (
    .req   (ready_vec),
    .idx   (ready_idx),
    .found (ready_found)
  );

  // Incoming operands may be satisfied by a broadcast in the same cycle
  always_comb begin
    new_j = snoop('{busy: issue_Qj_busy, tag: issue_Qj, value: issue_Vj},
                  alu_enable, alu_RobId, alu_value, lsb_enable, lsb_RobId, lsb_value);
    new_k = snoop('{busy: issue_Qk_busy, tag: issue_Qk, value: issue_Vk},
                  alu_enable, alu_RobId, alu_value, lsb_enable, lsb_RobId, lsb_value);
  end

  // Next state: flush, wakeup, dispatch and issue
  always_comb begin
    ent_d      = ent_q;
    out_d      = out_q;
    rs_valid_d = 1'b0;
    if (rdy) begin
      if (jump_flag) begin
        for (int i = 0; i < RS_N; i++) begin
          ent_d[i].busy = 1'b0;
        end
      end else begin
        for (int i = 0; i < RS_N; i++) begin
          if (ent_q[i].busy) begin
            ent_d[i].j = snoop(ent_q[i].j, alu_enable, alu_RobId, alu_value,
                               lsb_enable, lsb_RobId, lsb_value);
            ent_d[i].k = snoop(ent_q[i].k, alu_enable, alu_RobId, alu_value,
                               lsb_enable, lsb_RobId, lsb_value);
          end
        end
        if (ready_found) begin
          out_d.op               = ent_q[ready_idx].op;
          out_d.vj               = ent_q[ready_idx].j.value;
          out_d.vk               = ent_q[ready_idx].k.value;
          out_d.imm              = ent_q[ready_idx].imm;
          out_d.cur_pc           = ent_q[ready_idx].cur_pc;
          out_d.dest_rob         = ent_q[ready_idx].dest_rob;
          rs_valid_d             = 1'b1;
          ent_d[ready_idx].busy  = 1'b0;
        end
        // The free slot was chosen before dispatch, so a just-freed slot is not reused
        if (issue_valid && free_found) begin
          ent_d[free_idx].busy     = 1'b1;
          ent_d[free_idx].op       = issue_op;
          ent_d[free_idx].j        = new_j;
          ent_d[free_idx].k        = new_k;
          ent_d[free_idx].imm      = issue_Imm;
          ent_d[free_idx].dest_rob = issue_DestRob;
          ent_d[free_idx].cur_pc   = issue_CurPC;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_N; i++) begin
        ent_q[i] <= '0;
      end
      out_q      <= '0;
      rs_valid_q <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      out_q      <= out_d;
      rs_valid_q <= rs_valid_d;
    end
  end

  assign RS_valid   = rs_valid_q;
  assign RS_op      = out_q.op;
  assign RS_Vj      = out_q.vj;
  assign RS_Vk      = out_q.vk;
  assign RS_Imm     = out_q.imm;
  assign RS_CurPC   = out_q.cur_pc;
  assign RS_DestRob = out_q.dest_rob;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for the reservation station
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic               clk = 1'b0;
  logic               rst, rdy, jump_flag, issue_valid;
  logic [OP_LOG-1:0]  issue_op;
  logic [31:0]        issue_Vj, issue_Vk, issue_Imm, issue_CurPC;
  logic               issue_Qj_busy, issue_Qk_busy;
  logic [ROB_LOG-1:0] issue_Qj, issue_Qk, issue_DestRob;
  logic               full;
  logic               alu_enable, lsb_enable;
  logic [ROB_LOG-1:0] alu_RobId, lsb_RobId;
  logic [31:0]        alu_value, lsb_value;
  logic               RS_valid;
  logic [OP_LOG-1:0]  RS_op;
  logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROB_LOG-1:0] RS_DestRob;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_Imm(issue_Imm), .issue_CurPC(issue_CurPC), .issue_DestRob(issue_DestRob),
    .full(full),
    .alu_enable(alu_enable), .alu_RobId(alu_RobId), .alu_value(alu_value),
    .lsb_enable(lsb_enable), .lsb_RobId(lsb_RobId), .lsb_value(lsb_value),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected dispatches
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest;
    int                 at;
  } exp_t;

  typedef struct {
    bit                 used;
    logic [OP_LOG-1:0]  op;
    bit                 wj, wk;
    logic [ROB_LOG-1:0] tj, tk;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest;
  } slot_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  slot_t m[16];

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 16; i++) if (m[i].used) c++;
    return c;
  endfunction

  // An operand waiting on a tag takes a matching broadcast value; ALU first
  function automatic slot_t wake(slot_t s);
    slot_t r = s;
    if (r.wj && alu_enable && alu_RobId == r.tj) begin r.vj = alu_value; r.wj = 0; end
    else if (r.wj && lsb_enable && lsb_RobId == r.tj) begin r.vj = lsb_value; r.wj = 0; end
    if (r.wk && alu_enable && alu_RobId == r.tk) begin r.vk = alu_value; r.wk = 0; end
    else if (r.wk && lsb_enable && lsb_RobId == r.tk) begin r.vk = lsb_value; r.wk = 0; end
    return r;
  endfunction

  // Apply the current inputs to the model as the next clock edge will
  task automatic model_step();
    int pick = -1;
    int slot = -1;
    slot_t s;
    if (rst || (rdy && jump_flag)) begin
      for (int i = 0; i < 16; i++) m[i].used = 0;
      return;
    end
    if (!rdy) return;
    for (int i = 15; i >= 0; i--) begin
      if (m[i].used && !m[i].wj && !m[i].wk) pick = i;
      if (!m[i].used) slot = i;
    end
    if (pick >= 0) begin
      exp_q.push_back('{op: m[pick].op, vj: m[pick].vj, vk: m[pick].vk, imm: m[pick].imm,
                        pc: m[pick].pc, dest: m[pick].dest, at: cyc + 1});
      m[pick].used = 0;
    end
    for (int i = 0; i < 16; i++) if (m[i].used) m[i] = wake(m[i]);
    if (issue_valid && slot >= 0) begin
      s = '{used: 1, op: issue_op, wj: issue_Qj_busy, wk: issue_Qk_busy,
            tj: issue_Qj, tk: issue_Qk, vj: issue_Vj, vk: issue_Vk,
            imm: issue_Imm, pc: issue_CurPC, dest: issue_DestRob};
      m[slot] = wake(s);
    end
  endtask

  // Monitor: every dispatch must match the oldest outstanding expectation, on time
  always @(negedge clk) begin
    if (rst === 1'b0 && RS_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dispatch_unexpected cyc=%0d op=%0d vj=%h dest=%0d, required no dispatch",
                 cyc, RS_op, RS_Vj, RS_DestRob);
      end else begin
        mon_e = exp_q.pop_front();
        if (RS_op !== mon_e.op || RS_Vj !== mon_e.vj || RS_Vk !== mon_e.vk ||
            RS_Imm !== mon_e.imm || RS_CurPC !== mon_e.pc || RS_DestRob !== mon_e.dest ||
            cyc != mon_e.at) begin
          errors++;
          $display("FAIL dispatch got cyc=%0d op=%0d vj=%h vk=%h imm=%h pc=%h dest=%0d required cyc=%0d op=%0d vj=%h vk=%h imm=%h pc=%h dest=%0d",
                   cyc, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_CurPC, RS_DestRob,
                   mon_e.at, mon_e.op, mon_e.vj, mon_e.vk, mon_e.imm, mon_e.pc, mon_e.dest);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic idle();
    rdy = 1; jump_flag = 0; issue_valid = 0; alu_enable = 0; lsb_enable = 0;
  endtask

  task automatic issue(input logic [OP_LOG-1:0] op, input logic [31:0] vj, input bit qjb,
                       input logic [ROB_LOG-1:0] qj, input logic [31:0] vk, input bit qkb,
                       input logic [ROB_LOG-1:0] qk, input logic [31:0] imm,
                       input logic [ROB_LOG-1:0] dest);
    issue_valid = 1; issue_op = op; issue_Vj = vj; issue_Qj_busy = qjb; issue_Qj = qj;
    issue_Vk = vk; issue_Qk_busy = qkb; issue_Qk = qk; issue_Imm = imm;
    issue_CurPC = 32'h1000 + 32'(dest) * 4; issue_DestRob = dest;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("full", {31'd0, full}, {31'd0, model_count() == 16});
  endtask

  initial begin
    idle();
    rst = 1;
    issue_op = OP_NOP; issue_Vj = 0; issue_Vk = 0; issue_Qj_busy = 0; issue_Qk_busy = 0;
    issue_Qj = 0; issue_Qk = 0; issue_Imm = 0; issue_CurPC = 0; issue_DestRob = 0;
    alu_RobId = 0; alu_value = 0; lsb_RobId = 0; lsb_value = 0;
    step(); step();
    rst = 0;
    check("reset_valid", {31'd0, RS_valid}, 0);
    check("reset_op", {27'd0, RS_op}, 0);
    check("reset_vj", RS_Vj, 0);
    check("reset_vk", RS_Vk, 0);
    check("reset_imm", RS_Imm, 0);
    check("reset_pc", RS_CurPC, 0);
    check("reset_dest", {28'd0, RS_DestRob}, 0);

    // Ready issue
    issue(OP_ADD, 3, 0, 0, 4, 0, 0, 0, 5); step();
    idle(); step(); step(); step();

    // Wakeup through the load bus two cycles later
    issue(OP_ADDI, 0, 1, 7, 0, 0, 0, 1, 6); step();
    idle(); step();
    lsb_enable = 1; lsb_RobId = 7; lsb_value = 32'h10; step();
    idle(); step(); step();

    // Same-cycle issue and broadcast
    issue(OP_ADDI, 0, 1, 7, 0, 0, 0, 2, 8);
    lsb_enable = 1; lsb_RobId = 7; lsb_value = 32'h22; step();
    idle(); step(); step();

    // Fill all 16 slots waiting on tag 2, then try a 17th
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 0, 1, 2, 32'(i) + 100, 0, 0, 32'(i), 4'(i)); step();
    end
    check("full_after_16", {31'd0, full}, 1);
    issue(OP_SUB, 9, 0, 0, 9, 0, 0, 9, 9); step();
    check("full_after_17th", {31'd0, full}, 1);
    idle(); alu_enable = 1; alu_RobId = 2; alu_value = 32'hABCD; step();
    idle();
    for (int i = 0; i < 18; i++) step();
    check("full_drained", {31'd0, full}, 0);

    // Flush with a concurrent issue
    for (int i = 0; i < 3; i++) begin
      issue(OP_OR, 0, 1, 9, 1, 0, 0, 0, 4'(i + 1)); step();
    end
    idle(); jump_flag = 1; issue(OP_AND, 5, 0, 0, 6, 0, 0, 0, 12); step();
    check("flush_full", {31'd0, full}, 0);
    check("flush_valid", {31'd0, RS_valid}, 0);
    idle(); alu_enable = 1; alu_RobId = 9; alu_value = 7; step();
    idle(); step(); step();

    // Stall with a ready entry
    issue(OP_XOR, 32'h55, 0, 0, 32'hAA, 0, 0, 3, 11); step();
    idle(); rdy = 0; step(); step(); step();
    rdy = 1; step(); step();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      jump_flag = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6)
        issue(OP_LOG'($urandom_range(1, 15)), $urandom, $urandom_range(0, 1) == 1,
              ROB_LOG'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
              ROB_LOG'($urandom_range(0, 7)), $urandom, ROB_LOG'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 4) begin
        alu_enable = 1; alu_RobId = ROB_LOG'($urandom_range(0, 7)); alu_value = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        lsb_enable = 1; lsb_RobId = ROB_LOG'($urandom_range(0, 7)); lsb_value = $urandom;
        if (alu_enable && lsb_RobId == alu_RobId) lsb_RobId = lsb_RobId ^ 4'd1;
      end
      step();
    end

    // Drain: wake every tag, then let the station empty
    for (int t = 0; t < 16; t++) begin
      idle(); alu_enable = 1; alu_RobId = 4'(t); alu_value = 32'(t) * 3; step();
    end
    idle();
    for (int i = 0; i < 24; i++) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
